// File: rtl/fp16_pkg.sv
// fp16_pkg: fp16 format constants, adder FSM states, operand classes and an unpack helper
package fp16_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS = 15;
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_PACK, S_DONE} state_t;
  typedef enum logic [1:0] {C_ZERO, C_NORM, C_INF, C_NAN} cls_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0] man;
    cls_t cls;
  } op_t;
  function automatic op_t unpack_op(input logic [15:0] x, input bit flush);
    logic den;
    den = x[14:10] == '0;
    unpack_op.sign = x[15];
    unpack_op.exp = (den && !flush) ? 5'd1 : x[14:10];
    unpack_op.man = den ? (flush ? '0 : {1'b0, x[9:0]}) : {1'b1, x[9:0]};
    unpack_op.cls = den ? ((flush || x[9:0] == '0) ? C_ZERO : C_NORM)
                  : x[14:10] == EXP_MAX ? (x[9:0] == '0 ? C_INF : C_NAN) : C_NORM;
  endfunction
endpackage

// File: rtl/fp16_lzc.sv
// fp16_lzc: leading-zero count of a 15-bit value (15 when zero); ports: x in, n out
module fp16_lzc (
  input  logic [14:0] x,
  output logic [3:0]  n
);
  always_comb begin
    n = 4'd15;
    for (int i = 0; i < 15; i++) n = x[i] ? 4'(14 - i) : n;
  end
endmodule

// File: rtl/fp16_add_unit.sv
// fp16_add_unit: multi-cycle fp16 adder, RNE, denormals flushed; ports: clk, rst_n, add, number1, number2 in; result, ready out
module fp16_add_unit
  import fp16_pkg::*;
#(
  parameter bit FLUSH_DENORM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add,
  input  logic [15:0] number1,
  input  logic [15:0] number2,
  output logic [15:0] result,
  output logic        ready
);
  state_t state;
  logic [15:0] op_a, op_b;
  op_t ua, ub, big, sml;
  logic s_big, sub, swap, zero_n, rnd;
  logic [EXP_W-1:0] e_big, diff;
  logic [13:0] sig_a, sig_b, full;
  logic [14:0] sum;
  logic [12:0] sig_n;
  logic signed [6:0] exp_n, e_r;
  logic [3:0] lz, sh;
  logic [MAN_W:0] m_r;
  logic [15:0] arith, pack_val;
  fp16_lzc u_lzc (.x(sum), .n(lz));
  always_comb begin
    swap = {ub.exp, ub.man} > {ua.exp, ua.man};
    big = swap ? ub : ua;
    sml = swap ? ua : ub;
    diff = big.exp - sml.exp;
    full = {sml.man, 3'b000};
    sh = lz - 4'd1;
    rnd = sig_n[2] & (sig_n[3] | sig_n[1] | sig_n[0]);
    m_r = {1'b0, sig_n[12:3]} + {{MAN_W{1'b0}}, rnd};
    e_r = exp_n + $signed({6'd0, m_r[MAN_W]});
    arith = zero_n ? 16'h0000
          : e_r >= $signed({2'b00, EXP_MAX}) ? {s_big, POS_INF[14:0]}
          : e_r <= 7'sd0 ? {s_big, 15'h0000}
          : {s_big, e_r[4:0], m_r[MAN_W-1:0]};
    pack_val = (ua.cls == C_NAN || ub.cls == C_NAN || (ua.cls == C_INF && ub.cls == C_INF && ua.sign != ub.sign)) ? QNAN
             : ua.cls == C_INF ? {ua.sign, POS_INF[14:0]}
             : ub.cls == C_INF ? {ub.sign, POS_INF[14:0]}
             : (ua.cls == C_ZERO && ub.cls == C_ZERO) ? {ua.sign & ub.sign, 15'h0000}
             : arith;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ready <= 1'b0;
      result <= '0;
      op_a <= '0;
      op_b <= '0;
      ua <= '0;
      ub <= '0;
      s_big <= 1'b0;
      sub <= 1'b0;
      e_big <= '0;
      sig_a <= '0;
      sig_b <= '0;
      sum <= '0;
      sig_n <= '0;
      exp_n <= '0;
      zero_n <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          op_a <= add ? number1 : op_a;
          op_b <= add ? number2 : op_b;
          state <= add ? S_UNPACK : S_IDLE;
        end
        S_UNPACK: begin
          ua <= unpack_op(op_a, FLUSH_DENORM);
          ub <= unpack_op(op_b, FLUSH_DENORM);
          state <= S_ALIGN;
        end
        S_ALIGN: begin
          s_big <= big.sign;
          sub <= ua.sign ^ ub.sign;
          e_big <= big.exp;
          sig_a <= {big.man, 3'b000};
          // everything shifted past the S position collapses into it as sticky
          sig_b <= (full >> diff) | {13'd0, |(full & ~(14'h3FFF << diff))};
          state <= S_ADDSUB;
        end
        S_ADDSUB: begin
          sum <= sub ? {1'b0, sig_a} - {1'b0, sig_b} : {1'b0, sig_a} + {1'b0, sig_b};
          state <= S_NORM;
        end
        S_NORM: begin
          // hidden bit dropped: sig_n holds mantissa plus G/R/S
          sig_n <= sum[14] ? {sum[13:2], sum[1] | sum[0]} : 13'(sum << sh);
          exp_n <= sum[14] ? $signed({2'b00, e_big}) + 7'sd1 : $signed({2'b00, e_big}) - $signed({3'b000, sh});
          zero_n <= sum == '0;
          state <= S_PACK;
        end
        S_PACK: begin
          result <= pack_val;
          ready <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          ready <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
